johnson_monitor: RTL
====================

# johnson_monitor

Downstream checker for the 8-bit Johnson counter output bus. It samples the counter's code every clock and decodes it to a step index. It verifies that each sample is a legal Johnson code and the legal successor (or a hold) of the previous one, and gains/loses lock through a small state machine. It keeps saturating error and wrap counters for on-chip self-test readout.

## Interface
- `WIDTH`, 8, Johnson register width; sequence length is 2*WIDTH.
- `LOCK_COUNT`, 4, consecutive correct steps required to enter LOCKED (1..15).
- `ALLOW_HOLD`, 1, 1: an unchanged code is legal; 0: an unchanged code is a step error.
- `IW`, derived = $clog2(2*WIDTH) (4 at default); not overridable.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `code_in`  in  WIDTH  Johnson counter output (uo_out of the counter).
- `clear`  in  1  synchronous clear of err_count, wrap_count, err_sticky; has no effect on lock state.
- `step_out`  out  IW  decoded index of the last legal code.
- `code_valid`  out  1  last sampled code was legal.
- `locked`  out  1  monitor is in LOCKED.
- `err_sticky`  out  1  set on any counted error; cleared only by reset or clear.
- `err_count`  out  8  saturating count of errors while LOCKED.
- `wrap_count`  out  8  saturating count of index 2*WIDTH-1 -> 0 transitions while LOCKED.

## Operation
- Legal codes (WIDTH=8):
  - ones filling bits [k-1:0], k=0..WIDTH: index = popcount (0x00->0, 0x01->1, 0x03->2, ... 0xFF->8).
  - ones filling bits [WIDTH-1:m], m=1..WIDTH-1: index = 2*WIDTH - popcount (0xFE->9, ... 0x80->15).
  - any other pattern is illegal (e.g. 0x05, 0x81).
- Stage 1: code_q <= code_in.
- Stage 2: decode code_q; register results; compare against prev_idx (= current step_out) and prev_valid.
- Successor rule: new == (prev+1) mod 2*WIDTH is a good step. new == prev is a hold: legal if ALLOW_HOLD, otherwise a bad step. Anything else is a bad step.
- Illegal code: code_valid=0; step_out and prev_idx hold; prev_valid<=0.
- FSM states:
  - HUNT: legal code with prev_valid=0 -> record only, run stays 0. Good step -> run+1. Hold -> run unchanged. Bad step or illegal code -> run<=0, no count. Transition to LOCKED on the edge where run+1 == LOCK_COUNT.
  - LOCKED: good step or hold -> stay. Bad step or illegal code -> err_count+1 (saturate at 255), err_sticky<=1, run<=0, go to HUNT on the same edge. Good step 2*WIDTH-1 -> 0 -> wrap_count+1 (saturate at 255).
- clear in the same cycle as an error or wrap: clear wins, and the counters read 0 after the edge. The lock transition still happens.
- Reset values: step_out=0, code_valid=0, locked=0, err_sticky=0, err_count=0, wrap_count=0, code_q=0, run=0, prev_valid=0, state=HUNT.
- Async reset mid-operation: all registers return to reset values immediately. The first legal code after release only seeds prev_idx.

## Timing
- Latency: code_in stable before edge N is captured at N. step_out, code_valid, locked, and the counters reflect it after edge N+1 (2 cycles).
- Outputs are all registered; no combinational path from code_in to any output.
- locked, err_count, err_sticky, and wrap_count update on the same edge as the step_out for the triggering sample.
- Decode plus compare is a single cycle of logic after code_q. There is no backpressure and no handshake; the monitor accepts one sample per clock.

## Test plan
- Lock-up: after reset, drive the legal sequence 0x00,0x01,0x03,0x07,0x0F, one per clock.
  - step_out 0..4 appears 2 cycles after each code.
  - locked=1 on the edge step_out becomes 4 (LOCK_COUNT=4); err_count=0.
- Wrap: hold locked through 0x00..0x80 and back to 0x00.
  - wrap_count=1 on the edge step_out goes 15->0; locked stays 1.
- Skip error: while locked at 0x03, drive 0x0F.
  - On the same edge step_out=4: err_count=1, err_sticky=1, locked=0.
  - Relock after 4 more good steps.
- Illegal code: while locked at index 5, drive 0x05.
  - code_valid=0, step_out holds 5, err_count+1, locked=0.
  - Next code 0x7F only seeds prev (run=0).
- Hold and saturation:
  - ALLOW_HOLD=1, repeat 0x07 for 3 clocks: no error, locked stays 1.
  - Force 300 errors: err_count=255. Assert clear: err_count=0, err_sticky=0 one edge later.
- Async reset mid-lock: pulse rst_n low between edges.
  - All outputs go to 0 immediately without waiting for a clock edge.
  - Relock requires LOCK_COUNT+1 legal codes.

Source files
------------

// File: rtl/johnson_monitor.sv
// Checker for an 8-bit-style Johnson counter bus: decodes each sample to a step
// index, checks it is the legal successor of the last one, and tracks lock.
module johnson_monitor #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int ALLOW_HOLD = 1,
  localparam int IW        = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] code_in,
  input  logic             clear,
  output logic [IW-1:0]    step_out,
  output logic             code_valid,
  output logic             locked,
  output logic             err_sticky,
  output logic [7:0]       err_count,
  output logic [7:0]       wrap_count
);

  // state  | meaning
  // HUNT   | counting consecutive good steps toward lock
  // LOCKED | sequence trusted; deviations are counted as errors
  typedef enum logic {HUNT, LOCKED} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(2*WIDTH-1);
  localparam logic [IW:0]   SEQ_LEN  = (IW+1)'(2*WIDTH);

  state_t           state, nxt_state;
  logic [WIDTH-1:0] code_q;
  logic             prev_valid;
  logic [3:0]       run, nxt_run;

  logic [IW:0]      ones;
  logic [WIDTH-1:0] inc_q, inv_q;
  logic             low_fill, high_fill, dec_legal;
  logic [IW-1:0]    dec_idx, succ_idx;
  logic             is_good, is_hold, step_ok;
  logic             err_evt, wrap_evt;

  // Low-fill codes have no 1 above a 0; high-fill codes are the complement of that
  // with bit 0 clear and the top bit set (all-zeros / all-ones belong to low-fill).
  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) ones = ones + (IW+1)'(code_q[i]);
    inc_q     = code_q + WIDTH'(1);
    inv_q     = ~code_q;
    low_fill  = (code_q & inc_q) == '0;
    high_fill = ((inv_q & (inv_q + WIDTH'(1))) == '0) && code_q[WIDTH-1] && !code_q[0];
    dec_legal = low_fill || high_fill;
    dec_idx   = low_fill ? IW'(ones) : IW'(SEQ_LEN - ones);
  end

  always_comb begin
    succ_idx = (step_out == LAST_IDX) ? '0 : step_out + IW'(1);
    is_good  = dec_legal && prev_valid && (dec_idx == succ_idx);
    is_hold  = dec_legal && prev_valid && (dec_idx == step_out);
    step_ok  = is_good || (is_hold && (ALLOW_HOLD != 0));
  end

  always_comb begin
    nxt_state = state;
    nxt_run   = run;
    err_evt   = 1'b0;
    wrap_evt  = 1'b0;
    case (state)
      HUNT: begin
        if (is_good) begin
          if (run + 4'd1 == 4'(LOCK_COUNT)) begin
            nxt_state = LOCKED;
            nxt_run   = '0;
          end else begin
            nxt_run = run + 4'd1;
          end
        end else if (!step_ok) begin
          nxt_run = '0;
        end
      end
      LOCKED: begin
        if (step_ok) begin
          wrap_evt = is_good && (step_out == LAST_IDX);
        end else begin
          err_evt   = 1'b1;
          nxt_state = HUNT;
          nxt_run   = '0;
        end
      end
      default: nxt_state = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= nxt_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q     <= '0;
      run        <= '0;
      step_out   <= '0;
      code_valid <= 1'b0;
      prev_valid <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
      err_sticky <= 1'b0;
    end else begin
      code_q     <= code_in;
      run        <= nxt_run;
      code_valid <= dec_legal;
      prev_valid <= dec_legal;
      if (dec_legal) step_out <= dec_idx;
      if (clear) begin
        err_count  <= '0;
        wrap_count <= '0;
        err_sticky <= 1'b0;
      end else begin
        if (err_evt) begin
          err_sticky <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
        if (wrap_evt && wrap_count != 8'hFF) wrap_count <= wrap_count + 8'd1;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule
